// File: rtl/space_invaders_pkg.sv
// Shared formation geometry defaults, FSM state encoding and width helper
// for the monster formation controller.
package space_invaders_pkg;

    localparam int unsigned DEF_ROWS       = 8;
    localparam int unsigned DEF_COLS       = 16;
    localparam int unsigned DEF_CELL_SHIFT = 5;
    localparam int unsigned OFFSET_W       = 11;
    localparam int unsigned COUNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/monster_matrix_ctrl_if.sv
// Hit request/response bundle between the shot logic (master) and the
// formation controller (slave).
interface monster_matrix_ctrl_if;
    import space_invaders_pkg::*;

    logic                hitRequest;
    logic [OFFSET_W-1:0] hitOffsetX;
    logic [OFFSET_W-1:0] hitOffsetY;
    logic                hitAck;
    logic                scorePulse;
    logic                hitDropped;
    logic                busy;

    modport master (
        output hitRequest, hitOffsetX, hitOffsetY,
        input  hitAck, scorePulse, hitDropped, busy
    );

    modport slave (
        input  hitRequest, hitOffsetX, hitOffsetY,
        output hitAck, scorePulse, hitDropped, busy
    );

endinterface

// File: rtl/hit_cell_decode.sv
// Converts a pixel offset inside the formation bracket into a cell
// row/column and flags offsets that fall outside the populated grid.
module hit_cell_decode
    import space_invaders_pkg::*;
#(
    parameter int unsigned ROWS       = DEF_ROWS,
    parameter int unsigned COLS       = DEF_COLS,
    parameter int unsigned CELL_SHIFT = DEF_CELL_SHIFT,
    parameter int unsigned ROW_W      = idx_width(ROWS),
    parameter int unsigned COL_W      = idx_width(COLS)
) (
    input  logic [OFFSET_W-1:0] offset_x,
    input  logic [OFFSET_W-1:0] offset_y,
    output logic [ROW_W-1:0]    row,
    output logic [COL_W-1:0]    col,
    output logic                in_range
);

    logic [OFFSET_W-1:0] row_full;
    logic [OFFSET_W-1:0] col_full;

    // Range test uses the full-width cell index so large offsets cannot alias.
    always_comb begin
        row_full = offset_y >> CELL_SHIFT;
        col_full = offset_x >> CELL_SHIFT;
        in_range = (row_full < OFFSET_W'(ROWS)) && (col_full < OFFSET_W'(COLS));
        row      = row_full[ROW_W-1:0];
        col      = col_full[COL_W-1:0];
    end

endmodule

// File: rtl/monster_matrix_ctrl.sv
// Alive-matrix controller: decodes hit requests into cells, kills live
// monsters, keeps a running alive count and buffers one pending request.
module monster_matrix_ctrl
    import space_invaders_pkg::*;
#(
    parameter int unsigned ROWS       = DEF_ROWS,
    parameter int unsigned COLS       = DEF_COLS,
    parameter int unsigned CELL_SHIFT = DEF_CELL_SHIFT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startLevel,
    input  logic                      hitRequest,
    input  logic [OFFSET_W-1:0]       hitOffsetX,
    input  logic [OFFSET_W-1:0]       hitOffsetY,
    output logic [ROWS-1:0][COLS-1:0] mat,
    output logic                      hitAck,
    output logic                      scorePulse,
    output logic                      hitDropped,
    output logic [COUNT_W-1:0]        aliveCount,
    output logic                      allDead,
    output logic                      busy
);

    localparam int unsigned ROW_W = idx_width(ROWS);
    localparam int unsigned COL_W = idx_width(COLS);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(ROWS * COLS);

    state_e                   state_q, state_d;
    logic [ROWS-1:0][COLS-1:0] mat_q, mat_d;
    logic [COUNT_W-1:0]       alive_q, alive_d;
    logic                     all_dead_q, all_dead_d;
    logic                     ack_q, ack_d;
    logic                     score_q, score_d;
    logic                     drop_q, drop_d;
    logic [ROW_W-1:0]         cur_row_q, cur_row_d;
    logic [COL_W-1:0]         cur_col_q, cur_col_d;
    logic                     cur_in_q, cur_in_d;
    logic                     pend_valid_q, pend_valid_d;
    logic [ROW_W-1:0]         pend_row_q, pend_row_d;
    logic [COL_W-1:0]         pend_col_q, pend_col_d;
    logic                     pend_in_q, pend_in_d;

    logic [ROW_W-1:0]         dec_row;
    logic [COL_W-1:0]         dec_col;
    logic                     dec_in;
    logic                     hit_live;

    hit_cell_decode #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .CELL_SHIFT (CELL_SHIFT),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W)
    ) u_decode (
        .offset_x (hitOffsetX),
        .offset_y (hitOffsetY),
        .row      (dec_row),
        .col      (dec_col),
        .in_range (dec_in)
    );

    always_comb begin
        state_d      = state_q;
        mat_d        = mat_q;
        alive_d      = alive_q;
        all_dead_d   = (alive_q == '0);
        ack_d        = 1'b0;
        score_d      = 1'b0;
        drop_d       = 1'b0;
        cur_row_d    = cur_row_q;
        cur_col_d    = cur_col_q;
        cur_in_d     = cur_in_q;
        pend_valid_d = pend_valid_q;
        pend_row_d   = pend_row_q;
        pend_col_d   = pend_col_q;
        pend_in_d    = pend_in_q;
        hit_live     = cur_in_q && mat_q[cur_row_q][cur_col_q];

        if (startLevel) begin
            state_d      = ST_IDLE;
            mat_d        = '1;
            alive_d      = FULL_COUNT;
            all_dead_d   = 1'b0;
            pend_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (hitRequest) begin
                        cur_row_d = dec_row;
                        cur_col_d = dec_col;
                        cur_in_d  = dec_in;
                        state_d   = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state_d = ST_CLEAR;
                    ack_d   = 1'b1;
                    if (hit_live) begin
                        mat_d[cur_row_q][cur_col_q] = 1'b0;
                        score_d = 1'b1;
                        if (alive_q != '0) begin
                            alive_d = alive_q - 1'b1;
                        end
                    end
                    if (hitRequest) begin
                        if (pend_valid_q) begin
                            drop_d = 1'b1;
                        end else begin
                            pend_valid_d = 1'b1;
                            pend_row_d   = dec_row;
                            pend_col_d   = dec_col;
                            pend_in_d    = dec_in;
                        end
                    end
                end
                ST_CLEAR: begin
                    // An empty buffer lets a request arriving now go straight to CHECK.
                    if (pend_valid_q) begin
                        cur_row_d    = pend_row_q;
                        cur_col_d    = pend_col_q;
                        cur_in_d     = pend_in_q;
                        pend_valid_d = 1'b0;
                        state_d      = ST_CHECK;
                        drop_d       = hitRequest;
                    end else if (hitRequest) begin
                        cur_row_d = dec_row;
                        cur_col_d = dec_col;
                        cur_in_d  = dec_in;
                        state_d   = ST_CHECK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mat_q        <= '0;
            alive_q      <= '0;
            all_dead_q   <= 1'b1;
            ack_q        <= 1'b0;
            score_q      <= 1'b0;
            drop_q       <= 1'b0;
            cur_row_q    <= '0;
            cur_col_q    <= '0;
            cur_in_q     <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_row_q   <= '0;
            pend_col_q   <= '0;
            pend_in_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mat_q        <= mat_d;
            alive_q      <= alive_d;
            all_dead_q   <= all_dead_d;
            ack_q        <= ack_d;
            score_q      <= score_d;
            drop_q       <= drop_d;
            cur_row_q    <= cur_row_d;
            cur_col_q    <= cur_col_d;
            cur_in_q     <= cur_in_d;
            pend_valid_q <= pend_valid_d;
            pend_row_q   <= pend_row_d;
            pend_col_q   <= pend_col_d;
            pend_in_q    <= pend_in_d;
        end
    end

    assign mat        = mat_q;
    assign aliveCount = alive_q;
    assign allDead    = all_dead_q;
    assign hitAck     = ack_q;
    assign scorePulse = score_q;
    assign hitDropped = drop_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_monster_matrix_ctrl.sv
// Directed bench for monster_matrix_ctrl: reset, level start, hits, misses,
// request buffering, full clear, start priority and reset abort.
module tb_monster_matrix_ctrl;

    logic            clk;
    logic            reset;
    logic            startLevel;
    logic [7:0][15:0] mat;
    logic [7:0]      aliveCount;
    logic            allDead;

    logic [7:0][15:0] exp_mat;
    int unsigned     exp_count;
    int unsigned     n_checks;
    int unsigned     n_fail;

    monster_matrix_ctrl_if bus ();

    monster_matrix_ctrl #(
        .ROWS       (8),
        .COLS       (16),
        .CELL_SHIFT (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .startLevel (startLevel),
        .hitRequest (bus.hitRequest),
        .hitOffsetX (bus.hitOffsetX),
        .hitOffsetY (bus.hitOffsetY),
        .mat        (mat),
        .hitAck     (bus.hitAck),
        .scorePulse (bus.scorePulse),
        .hitDropped (bus.hitDropped),
        .aliveCount (aliveCount),
        .allDead    (allDead),
        .busy       (bus.busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        startLevel = 1'b0;
        bus.hitRequest = 1'b0;
        bus.hitOffsetX = '0;
        bus.hitOffsetY = '0;
        repeat (3) step();
        n_checks++; if (mat !== '0) begin n_fail++; $display("FAIL reset_mat: got %h want 0", mat); end
        n_checks++; if (aliveCount !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", aliveCount); end
        n_checks++; if (allDead !== 1'b1) begin n_fail++; $display("FAIL reset_alldead: got %b want 1", allDead); end
        n_checks++; if ({bus.hitAck, bus.scorePulse, bus.hitDropped, bus.busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 0000", {bus.hitAck, bus.scorePulse, bus.hitDropped, bus.busy});
        end
        reset = 1'b0;
        step();
        exp_mat = '0;
        exp_count = 0;
    endtask

    task automatic test_start_level();
        startLevel = 1'b1;
        step();
        startLevel = 1'b0;
        exp_mat = '1;
        exp_count = 128;
        n_checks++; if (mat !== exp_mat) begin n_fail++; $display("FAIL start_mat: got %h want all ones", mat); end
        n_checks++; if (aliveCount !== 8'd128) begin n_fail++; $display("FAIL start_count: got %0d want 128", aliveCount); end
        n_checks++; if (allDead !== 1'b0) begin n_fail++; $display("FAIL start_alldead: got %b want 0", allDead); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_busy: got %b want 0", bus.busy); end
    endtask

    // Issues one isolated request; r/c/in_rng are the hand-decoded cell.
    task automatic send_hit(input logic [10:0] x, input logic [10:0] y,
                            input int unsigned r, input int unsigned c, input logic in_rng);
        logic exp_hit;
        exp_hit = in_rng ? exp_mat[r][c] : 1'b0;
        bus.hitRequest = 1'b1;
        bus.hitOffsetX = x;
        bus.hitOffsetY = y;
        step();
        bus.hitRequest = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL hit_busy x=%0d y=%0d: got %b want 1", x, y, bus.busy); end
        n_checks++; if (bus.hitAck !== 1'b0) begin n_fail++; $display("FAIL hit_early_ack x=%0d y=%0d: got %b want 0", x, y, bus.hitAck); end
        step();
        if (exp_hit) begin
            exp_mat[r][c] = 1'b0;
            exp_count = exp_count - 1;
        end
        n_checks++; if (bus.hitAck !== 1'b1) begin n_fail++; $display("FAIL hit_ack x=%0d y=%0d: got %b want 1", x, y, bus.hitAck); end
        n_checks++; if (bus.scorePulse !== exp_hit) begin n_fail++; $display("FAIL hit_score x=%0d y=%0d: got %b want %b", x, y, bus.scorePulse, exp_hit); end
        n_checks++; if (mat !== exp_mat) begin n_fail++; $display("FAIL hit_mat x=%0d y=%0d: got %h want %h", x, y, mat, exp_mat); end
        n_checks++; if (aliveCount !== 8'(exp_count)) begin n_fail++; $display("FAIL hit_count x=%0d y=%0d: got %0d want %0d", x, y, aliveCount, exp_count); end
        step();
        n_checks++; if ({bus.hitAck, bus.scorePulse, bus.busy} !== 3'b000) begin
            n_fail++; $display("FAIL hit_done x=%0d y=%0d: got ack/score/busy %b want 000", x, y, {bus.hitAck, bus.scorePulse, bus.busy});
        end
    endtask

    task automatic test_single_hit();
        send_hit(11'd70, 11'd40, 1, 2, 1'b1);
        n_checks++; if (aliveCount !== 8'd127) begin n_fail++; $display("FAIL single_count: got %0d want 127", aliveCount); end
    endtask

    task automatic test_misses();
        send_hit(11'd70, 11'd40, 1, 2, 1'b1);
        send_hit(11'd600, 11'd10, 0, 18, 1'b0);
        send_hit(11'd10, 11'd256, 8, 0, 1'b0);
        send_hit(11'd2047, 11'd2047, 63, 63, 1'b0);
        n_checks++; if (aliveCount !== 8'd127) begin n_fail++; $display("FAIL miss_count: got %0d want 127", aliveCount); end
    endtask

    task automatic test_back_to_back();
        bus.hitRequest = 1'b1; bus.hitOffsetX = 11'd5;   bus.hitOffsetY = 11'd5;
        step();
        bus.hitRequest = 1'b1; bus.hitOffsetX = 11'd40;  bus.hitOffsetY = 11'd3;
        n_checks++; if (bus.hitAck !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_n1: got %b want 0", bus.hitAck); end
        step();
        bus.hitRequest = 1'b1; bus.hitOffsetX = 11'd100; bus.hitOffsetY = 11'd0;
        exp_mat[0][0] = 1'b0;
        n_checks++; if (bus.hitAck !== 1'b1 || bus.scorePulse !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first_ack: got ack %b score %b want 1 1", bus.hitAck, bus.scorePulse);
        end
        n_checks++; if (bus.hitDropped !== 1'b0) begin n_fail++; $display("FAIL b2b_drop_n2: got %b want 0", bus.hitDropped); end
        step();
        bus.hitRequest = 1'b0;
        n_checks++; if (bus.hitAck !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_n3: got %b want 0", bus.hitAck); end
        n_checks++; if (bus.hitDropped !== 1'b1) begin n_fail++; $display("FAIL b2b_drop_n3: got %b want 1", bus.hitDropped); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_n3: got %b want 1", bus.busy); end
        step();
        exp_mat[0][1] = 1'b0;
        exp_count = exp_count - 2;
        n_checks++; if (bus.hitAck !== 1'b1 || bus.scorePulse !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second_ack: got ack %b score %b want 1 1", bus.hitAck, bus.scorePulse);
        end
        n_checks++; if (bus.hitDropped !== 1'b0) begin n_fail++; $display("FAIL b2b_drop_n4: got %b want 0", bus.hitDropped); end
        n_checks++; if (mat !== exp_mat) begin n_fail++; $display("FAIL b2b_mat: got %h want %h", mat, exp_mat); end
        n_checks++; if (aliveCount !== 8'(exp_count)) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", aliveCount, exp_count); end
        step();
        n_checks++; if (bus.hitAck !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: got ack %b busy %b want 0 0", bus.hitAck, bus.busy);
        end
    endtask

    task automatic test_kill_all();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 16; c++) begin
                send_hit(11'(c * 32 + 7), 11'(r * 32 + 19), r, c, 1'b1);
            end
        end
        n_checks++; if (aliveCount !== 8'd0) begin n_fail++; $display("FAIL killall_count: got %0d want 0", aliveCount); end
        n_checks++; if (allDead !== 1'b1) begin n_fail++; $display("FAIL killall_alldead: got %b want 1", allDead); end
        send_hit(11'd0, 11'd0, 0, 0, 1'b1);
        n_checks++; if (aliveCount !== 8'd0) begin n_fail++; $display("FAIL killall_underflow: got %0d want 0", aliveCount); end
    endtask

    task automatic test_start_priority();
        startLevel = 1'b1;
        bus.hitRequest = 1'b1; bus.hitOffsetX = 11'd70; bus.hitOffsetY = 11'd40;
        step();
        startLevel = 1'b0;
        bus.hitRequest = 1'b0;
        exp_mat = '1;
        exp_count = 128;
        n_checks++; if (mat !== exp_mat) begin n_fail++; $display("FAIL prio_mat: got %h want all ones", mat); end
        n_checks++; if (aliveCount !== 8'd128 || allDead !== 1'b0) begin
            n_fail++; $display("FAIL prio_count: got %0d alldead %b want 128 0", aliveCount, allDead);
        end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL prio_busy: got %b want 0", bus.busy); end
        step();
        n_checks++; if ({bus.hitAck, bus.scorePulse, bus.hitDropped} !== 3'b000) begin
            n_fail++; $display("FAIL prio_pulses: got %b want 000", {bus.hitAck, bus.scorePulse, bus.hitDropped});
        end
        // In-flight request aborted by startLevel during CHECK.
        bus.hitRequest = 1'b1; bus.hitOffsetX = 11'd70; bus.hitOffsetY = 11'd40;
        step();
        bus.hitRequest = 1'b0;
        startLevel = 1'b1;
        step();
        startLevel = 1'b0;
        n_checks++; if (bus.hitAck !== 1'b0 || bus.scorePulse !== 1'b0) begin
            n_fail++; $display("FAIL abort_pulses: got ack %b score %b want 0 0", bus.hitAck, bus.scorePulse);
        end
        n_checks++; if (mat !== exp_mat || aliveCount !== 8'd128) begin
            n_fail++; $display("FAIL abort_state: got %h count %0d want all ones 128", mat, aliveCount);
        end
        step();
        n_checks++; if (bus.hitAck !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_after: got ack %b busy %b want 0 0", bus.hitAck, bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        bus.hitRequest = 1'b1; bus.hitOffsetX = 11'd70; bus.hitOffsetY = 11'd40;
        step();
        bus.hitRequest = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++; if (mat !== '0 || allDead !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rstabort_async: got mat %h alldead %b busy %b want 0 1 0", mat, allDead, bus.busy);
        end
        step();
        reset = 1'b0;
        step();
        n_checks++; if ({bus.hitAck, bus.scorePulse, bus.hitDropped, bus.busy} !== 4'b0000) begin
            n_fail++; $display("FAIL rstabort_pulses: got %b want 0000", {bus.hitAck, bus.scorePulse, bus.hitDropped, bus.busy});
        end
        n_checks++; if (aliveCount !== 8'd0) begin n_fail++; $display("FAIL rstabort_count: got %0d want 0", aliveCount); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_start_level();
        test_single_hit();
        test_misses();
        test_back_to_back();
        test_kill_all();
        test_start_priority();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
